// File: rtl/accel_mmio_sequencer.sv
// accel_mmio_sequencer
//   Takes one job over a valid/ready command port and runs it on a memory-mapped
//   accelerator. It writes the job registers, starts the accelerator and polls the
//   status register until DONE (bit 1) or until the poll budget runs out. It then
//   reads back one result register per lane and acknowledges DONE. The outcome is
//   held on a valid/ready result port until it is taken.
//
// Ports
//   clk, reset_n            : single clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   : job request; accepted when both are 1 at a clk edge
//   cmd_w_addr, cmd_x_addr  : operand base addresses passed to the accelerator
//   cmd_m_dim, cmd_n_dim    : lane count (1..4) and vector length (4..1024, multiple of 4)
//   res_valid / res_ready   : result handshake; res_* are stable while res_valid=1
//   res_err                 : job rejected or accelerator timed out (results are 0)
//   res_data0..res_data3    : raw lane results; lanes at or above m_dim read 0
//   mmio_*                  : accelerator register port. Writes use mmio_we=4'hF.
//                             Reads assert mmio_re, and mmio_rdata is valid one
//                             cycle later.
//   dbg_state               : current FSM state, for observation only
//
// Handshake rule for both cmd and res: a transfer happens on the rising clk edge
// where valid and ready are both 1. The producer holds its payload stable from
// raising valid until that edge.
module accel_mmio_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_w_addr,
  input  logic [31:0] cmd_x_addr,
  input  logic [2:0]  cmd_m_dim,
  input  logic [31:0] cmd_n_dim,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_err,
  output logic [31:0] res_data0,
  output logic [31:0] res_data1,
  output logic [31:0] res_data2,
  output logic [31:0] res_data3,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_we,
  output logic        mmio_re,
  input  logic [31:0] mmio_rdata,
  output logic [3:0]  dbg_state
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_W, WR_X, WR_M, WR_N, WR_GO, POLL_RQ, POLL_RS, RD_RQ, RD_RS, WR_ACK, RESP
  } state_t;

  state_t state, state_nx;

  logic [31:0]       w_q, x_q, n_q;
  logic [2:0]        m_q;
  logic [1:0]        lane_q;
  logic [PW-1:0]     poll_q;
  logic [3:0][31:0]  lane_d;   // shadow results; res_data* only change on entry to RESP

  logic accept, job_bad, done, poll_last, last_lane;

  assign accept    = cmd_valid && cmd_ready;
  assign job_bad   = (cmd_m_dim == 3'd0) || (cmd_m_dim > 3'd4) || (cmd_n_dim == 32'd0) ||
                     (cmd_n_dim[1:0] != 2'b00) || (cmd_n_dim > 32'd1024);
  assign done      = mmio_rdata[1];
  assign poll_last = (poll_q == PW'(POLL_LIMIT - 1));
  assign last_lane = ({1'b0, lane_q} == (m_q - 3'd1));

  // Gated with reset_n so the port reads not-ready while reset is held.
  assign cmd_ready = (state == IDLE) && reset_n;
  assign res_valid = (state == RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mmio_addr  = BASE_ADDR;
    mmio_wdata = 32'h0;
    mmio_we    = 4'h0;
    mmio_re    = 1'b0;
    case (state)
      IDLE:    if (accept) state_nx = job_bad ? RESP : WR_W;
      WR_W:    begin state_nx = WR_X;  mmio_we = 4'hF; mmio_addr = BASE_ADDR + 32'h04; mmio_wdata = w_q; end
      WR_X:    begin state_nx = WR_M;  mmio_we = 4'hF; mmio_addr = BASE_ADDR + 32'h08; mmio_wdata = x_q; end
      WR_M:    begin state_nx = WR_N;  mmio_we = 4'hF; mmio_addr = BASE_ADDR + 32'h0C; mmio_wdata = {29'h0, m_q}; end
      WR_N:    begin state_nx = WR_GO; mmio_we = 4'hF; mmio_addr = BASE_ADDR + 32'h10; mmio_wdata = n_q; end
      WR_GO:   begin state_nx = POLL_RQ; mmio_we = 4'hF; mmio_wdata = 32'h1; end
      POLL_RQ: begin state_nx = POLL_RS; mmio_re = 1'b1; end
      POLL_RS: begin
        if (done)           state_nx = RD_RQ;
        else if (poll_last) state_nx = RESP;
        else                state_nx = POLL_RQ;
      end
      RD_RQ:   begin
        state_nx  = RD_RS;
        mmio_re   = 1'b1;
        mmio_addr = BASE_ADDR + 32'h14 + {28'h0, lane_q, 2'b00};
      end
      RD_RS:   state_nx = last_lane ? WR_ACK : RD_RQ;
      WR_ACK:  begin state_nx = RESP; mmio_we = 4'hF; mmio_wdata = 32'h0; end
      RESP:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q       <= 32'h0;
      x_q       <= 32'h0;
      n_q       <= 32'h0;
      m_q       <= 3'd0;
      lane_q    <= 2'd0;
      poll_q    <= '0;
      lane_d    <= '0;
      res_err   <= 1'b0;
      res_data0 <= 32'h0;
      res_data1 <= 32'h0;
      res_data2 <= 32'h0;
      res_data3 <= 32'h0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          w_q    <= cmd_w_addr;
          x_q    <= cmd_x_addr;
          m_q    <= cmd_m_dim;
          n_q    <= cmd_n_dim;
          lane_q <= 2'd0;
          poll_q <= '0;
          lane_d <= '0;
          if (job_bad) begin
            res_err   <= 1'b1;
            res_data0 <= 32'h0;
            res_data1 <= 32'h0;
            res_data2 <= 32'h0;
            res_data3 <= 32'h0;
          end
        end
        POLL_RS: if (!done) begin
          if (poll_last) begin
            res_err   <= 1'b1;
            res_data0 <= 32'h0;
            res_data1 <= 32'h0;
            res_data2 <= 32'h0;
            res_data3 <= 32'h0;
          end else begin
            poll_q <= poll_q + PW'(1);
          end
        end
        RD_RS: begin
          lane_d[lane_q] <= mmio_rdata;
          if (!last_lane) lane_q <= lane_q + 2'd1;
        end
        WR_ACK: begin
          res_err   <= 1'b0;
          res_data0 <= lane_d[0];
          res_data1 <= lane_d[1];
          res_data2 <= lane_d[2];
          res_data3 <= lane_d[3];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_mmio_sequencer.sv
module tb_accel_mmio_sequencer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          PL   = 8;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_w_addr, cmd_x_addr, cmd_n_dim;
  logic [2:0]  cmd_m_dim;
  logic        res_valid, res_ready, res_err;
  logic [31:0] res_data0, res_data1, res_data2, res_data3;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_we;
  logic        mmio_re;
  logic [3:0]  dbg_state;

  accel_mmio_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_addr(cmd_w_addr), .cmd_x_addr(cmd_x_addr),
    .cmd_m_dim(cmd_m_dim), .cmd_n_dim(cmd_n_dim),
    .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err),
    .res_data0(res_data0), .res_data1(res_data1),
    .res_data2(res_data2), .res_data3(res_data3),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we),
    .mmio_re(mmio_re), .mmio_rdata(mmio_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0]      w, x, n;
    logic [2:0]       m;
    int               done_after;   // 0 = accelerator never reports DONE
    logic [3:0][31:0] lanes;
    logic             exp_err;
    int               hold;         // cycles res_ready stays low in RESP
  } job_t;

  int checks = 0;
  int errors = 0;
  logic [64:0]  exp_q[$];   // {is_write, addr, wdata}
  logic [128:0] res_q[$];   // {err, d3, d2, d1, d0}

  int               m_done_after;
  logic [3:0][31:0] m_lanes;
  int               m_status_reads;
  logic [64:0]      mon_rec;
  logic [31:0]      mon_idx;

  job_t tbl[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- accelerator model + MMIO monitor ----------------
  initial mmio_rdata = 32'h0;
  always begin
    @(posedge clk);
    #1;
    if (mmio_we != 4'h0 && mmio_re) begin
      checks++;
      errors++;
      $display("FAIL mmio_we_and_re act=both exp=one");
    end else if (mmio_we != 4'h0 || mmio_re) begin
      if (mmio_we != 4'h0) begin
        mon_rec = {1'b1, mmio_addr, mmio_wdata};
        chk("mmio_we_mask", {124'h0, mmio_we}, 128'hF);
        if (mmio_addr == BASE) m_status_reads = 0;
      end else begin
        mon_rec = {1'b0, mmio_addr, 32'h0};
        if (mmio_addr == BASE) begin
          m_status_reads++;
          // Not-done status has every bit except DONE set.
          mmio_rdata = (m_done_after != 0 && m_status_reads >= m_done_after) ? 32'h2 : 32'hFFFF_FFFD;
        end else begin
          mon_idx = (mmio_addr - BASE - 32'h14) >> 2;
          mmio_rdata = (mon_idx < 4) ? m_lanes[mon_idx[1:0]] : 32'hDEAD_BEEF;
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mmio_unexpected act=%0h exp=none", mon_rec);
      end else begin
        chk("mmio_txn", {63'h0, mon_rec}, {63'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- expectation builder ----------------
  function automatic logic job_is_bad(input job_t j);
    return (j.m == 3'd0) || (j.m > 3'd4) || (j.n == 32'd0) || (j.n[1:0] != 2'b00) || (j.n > 32'd1024);
  endfunction

  task automatic push_expect(input job_t j);
    logic [3:0][31:0] d;
    logic err;
    int p;
    d   = '0;
    err = j.exp_err;
    if (!job_is_bad(j)) begin
      exp_q.push_back({1'b1, BASE + 32'h04, j.w});
      exp_q.push_back({1'b1, BASE + 32'h08, j.x});
      exp_q.push_back({1'b1, BASE + 32'h0C, {29'h0, j.m}});
      exp_q.push_back({1'b1, BASE + 32'h10, j.n});
      exp_q.push_back({1'b1, BASE, 32'h1});
      p = (j.done_after == 0) ? PL : j.done_after;
      for (int i = 0; i < p; i++) exp_q.push_back({1'b0, BASE, 32'h0});
      if (j.done_after != 0) begin
        for (int k = 0; k < int'(j.m); k++) exp_q.push_back({1'b0, BASE + 32'h14 + 32'(4 * k), 32'h0});
        exp_q.push_back({1'b1, BASE, 32'h0});
      end
    end
    if (!err) for (int k = 0; k < int'(j.m); k++) d[k] = j.lanes[k];
    res_q.push_back({err, d[3], d[2], d[1], d[0]});
  endtask

  // ---------------- driver ----------------
  task automatic drive_cmd(input job_t j);
    @(posedge clk);
    #2;
    cmd_valid  = 1'b1;
    cmd_w_addr = j.w;
    cmd_x_addr = j.x;
    cmd_m_dim  = j.m;
    cmd_n_dim  = j.n;
    chk("cmd_ready_idle", {127'h0, cmd_ready}, 128'h1);
    @(posedge clk);
    #2;
    cmd_valid  = 1'b0;
    cmd_w_addr = $urandom;
    cmd_x_addr = $urandom;
    cmd_m_dim  = 3'($urandom_range(0, 7));
    cmd_n_dim  = $urandom;
  endtask

  task automatic run_job(input job_t j, input string tag);
    logic [128:0] exp_r, snap;
    int cnt;
    m_done_after = j.done_after;
    m_lanes      = j.lanes;
    push_expect(j);
    drive_cmd(j);
    if (job_is_bad(j)) chk({tag, "_reject_next_cycle"}, {127'h0, res_valid}, 128'h1);
    cnt = 0;
    while (!res_valid && cnt < 300) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    exp_r = res_q.pop_front();
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_res_timeout act=no_res_valid exp=res_valid", tag);
      exp_q.delete();
      return;
    end
    chk({tag, "_res_err"}, {127'h0, res_err}, {127'h0, exp_r[128]});
    chk({tag, "_res_data0"}, {96'h0, res_data0}, {96'h0, exp_r[31:0]});
    chk({tag, "_res_data1"}, {96'h0, res_data1}, {96'h0, exp_r[63:32]});
    chk({tag, "_res_data2"}, {96'h0, res_data2}, {96'h0, exp_r[95:64]});
    chk({tag, "_res_data3"}, {96'h0, res_data3}, {96'h0, exp_r[127:96]});
    chk({tag, "_cmd_ready_resp"}, {127'h0, cmd_ready}, 128'h0);
    chk({tag, "_mmio_drained"}, 128'(exp_q.size()), 128'h0);
    exp_q.delete();
    snap = {res_err, res_data3, res_data2, res_data1, res_data0};
    for (int i = 0; i < j.hold; i++) begin
      @(posedge clk);
      #2;
      chk({tag, "_hold_valid"}, {127'h0, res_valid}, 128'h1);
      chk({tag, "_hold_data"}, {127'h0, {res_err, res_data3, res_data2, res_data1, res_data0} == snap}, 128'h1);
      chk({tag, "_hold_cmd_ready"}, {127'h0, cmd_ready}, 128'h0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    res_ready = 1'b0;
    chk({tag, "_res_taken"}, {127'h0, res_valid}, 128'h0);
    chk({tag, "_back_idle"}, {127'h0, cmd_ready}, 128'h1);
    chk({tag, "_data_kept"}, {127'h0, {res_err, res_data3, res_data2, res_data1, res_data0} == snap}, 128'h1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    job_t j;
    int cnt;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_w_addr = 32'h0; cmd_x_addr = 32'h0; cmd_m_dim = 3'd0; cmd_n_dim = 32'h0;
    res_ready = 1'b0;
    m_done_after = 0; m_lanes = '0; m_status_reads = 0;

    //            w            x            n        m     da lanes {3,2,1,0}                                                  err  hold
    tbl[0] = '{32'h1000,    32'h2000,    32'd8,    3'd4, 3, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10},                      1'b0, 10};
    tbl[1] = '{32'h3000,    32'h4000,    32'd4,    3'd2, 1, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},       1'b0, 0};
    tbl[2] = '{32'h10,      32'h20,      32'd6,    3'd1, 1, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 0};
    tbl[3] = '{32'h10,      32'h20,      32'd0,    3'd1, 1, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 0};
    tbl[4] = '{32'h10,      32'h20,      32'd8,    3'd5, 1, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 0};
    tbl[5] = '{32'h10,      32'h20,      32'd1028, 3'd4, 1, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 0};
    tbl[6] = '{32'h10,      32'h20,      32'd8,    3'd0, 1, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 0};
    tbl[7] = '{32'hCAFE_0000, 32'hBEEF_0000, 32'd1024, 3'd1, 2, {32'h5, 32'h6, 32'h7, 32'h8000_0001},                         1'b0, 2};
    tbl[8] = '{32'h0,       32'hFFFF_FFFC, 32'd12, 3'd3, PL, {32'h9, 32'h1234_5678, 32'h8765_4321, 32'h0F0F_F0F0},             1'b0, 0};
    tbl[9] = '{32'h5000,    32'h6000,    32'd16,   3'd4, 0, {32'h1, 32'h2, 32'h3, 32'h4},                                      1'b1, 3};

    // Reset values while reset_n is held low.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd_ready", {127'h0, cmd_ready}, 128'h0);
    chk("rst_res_valid", {127'h0, res_valid}, 128'h0);
    chk("rst_res_err", {127'h0, res_err}, 128'h0);
    chk("rst_res_data", {res_data3, res_data2, res_data1, res_data0}, 128'h0);
    chk("rst_mmio_we", {124'h0, mmio_we}, 128'h0);
    chk("rst_mmio_re", {127'h0, mmio_re}, 128'h0);
    chk("rst_mmio_addr", {96'h0, mmio_addr}, {96'h0, BASE});
    chk("rst_mmio_wdata", {96'h0, mmio_wdata}, 128'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_cmd_ready", {127'h0, cmd_ready}, 128'h1);

    for (int i = 0; i < 10; i++) run_job(tbl[i], $sformatf("tbl%0d", i));

    // Reset asserted while the sequencer is polling.
    j = '{32'h7000, 32'h7100, 32'd4, 3'd1, 0, {32'h0, 32'h0, 32'h0, 32'h55}, 1'b1, 0};
    m_done_after = 0;
    for (int i = 0; i < 5; i++) begin end
    exp_q.push_back({1'b1, BASE + 32'h04, j.w});
    exp_q.push_back({1'b1, BASE + 32'h08, j.x});
    exp_q.push_back({1'b1, BASE + 32'h0C, {29'h0, j.m}});
    exp_q.push_back({1'b1, BASE + 32'h10, j.n});
    exp_q.push_back({1'b1, BASE, 32'h1});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, BASE, 32'h0});
    drive_cmd(j);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    chk("midpoll_re_active", {127'h0, mmio_re}, 128'h1);
    reset_n = 1'b0;
    #1;
    chk("midpoll_rst_re", {127'h0, mmio_re}, 128'h0);
    chk("midpoll_rst_we", {124'h0, mmio_we}, 128'h0);
    chk("midpoll_rst_res_valid", {127'h0, res_valid}, 128'h0);
    chk("midpoll_rst_cmd_ready", {127'h0, cmd_ready}, 128'h0);
    chk("midpoll_rst_addr", {96'h0, mmio_addr}, {96'h0, BASE});
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    chk("midpoll_rst_quiet", {127'h0, mmio_re}, 128'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    chk("midpoll_post_rst_ready", {127'h0, cmd_ready}, 128'h1);
    run_job(tbl[0], "after_rst");

    // Random valid jobs.
    for (int r = 0; r < 4; r++) begin
      j.w = $urandom;
      j.x = $urandom;
      j.m = 3'($urandom_range(1, 4));
      j.n = 32'(4 * $urandom_range(1, 256));
      j.done_after = $urandom_range(1, PL);
      j.lanes = {$urandom, $urandom, $urandom, $urandom};
      j.exp_err = 1'b0;
      j.hold = $urandom_range(0, 3);
      run_job(j, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
